fft16_top: RTL and testbench

- 16-point, radix-2 FFT on real Q1.15 samples, with results in natural order.
- Samples are written one at a time into an internal 16-entry sample register file.
- A combinational 4-stage butterfly network computes the transform, and its result is registered onto 32 parallel output buses (16 real, 16 imaginary).
- Used as a block-level spectral front end: software or control logic loads a frame, then reads all bins in parallel.

---
 rtl/fft16_top.sv | 228 ++++++++++++++++++++++
 tb/tb_fft16_top.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_top.sv
// 16-point radix-2 decimation-in-time FFT on real Q1.15 samples. A 16-entry sample file
// feeds a combinational 4-stage butterfly network whose natural-order result is registered.
module fft16_top #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [3:0]              addr_in,
   input  logic signed [WIDTH-1:0] xr_in,
   output logic signed [WIDTH-1:0] yr_out0,
   output logic signed [WIDTH-1:0] yr_out1,
   output logic signed [WIDTH-1:0] yr_out2,
   output logic signed [WIDTH-1:0] yr_out3,
   output logic signed [WIDTH-1:0] yr_out4,
   output logic signed [WIDTH-1:0] yr_out5,
   output logic signed [WIDTH-1:0] yr_out6,
   output logic signed [WIDTH-1:0] yr_out7,
   output logic signed [WIDTH-1:0] yr_out8,
   output logic signed [WIDTH-1:0] yr_out9,
   output logic signed [WIDTH-1:0] yr_out10,
   output logic signed [WIDTH-1:0] yr_out11,
   output logic signed [WIDTH-1:0] yr_out12,
   output logic signed [WIDTH-1:0] yr_out13,
   output logic signed [WIDTH-1:0] yr_out14,
   output logic signed [WIDTH-1:0] yr_out15,
   output logic signed [WIDTH-1:0] yi_out0,
   output logic signed [WIDTH-1:0] yi_out1,
   output logic signed [WIDTH-1:0] yi_out2,
   output logic signed [WIDTH-1:0] yi_out3,
   output logic signed [WIDTH-1:0] yi_out4,
   output logic signed [WIDTH-1:0] yi_out5,
   output logic signed [WIDTH-1:0] yi_out6,
   output logic signed [WIDTH-1:0] yi_out7,
   output logic signed [WIDTH-1:0] yi_out8,
   output logic signed [WIDTH-1:0] yi_out9,
   output logic signed [WIDTH-1:0] yi_out10,
   output logic signed [WIDTH-1:0] yi_out11,
   output logic signed [WIDTH-1:0] yi_out12,
   output logic signed [WIDTH-1:0] yi_out13,
   output logic signed [WIDTH-1:0] yi_out14,
   output logic signed [WIDTH-1:0] yi_out15
);

   localparam int N      = 16;
   localparam int STAGES = 4;
   localparam int FRAC   = WIDTH - 1;

   typedef logic signed [WIDTH-1:0]   word_t;
   typedef logic signed [WIDTH:0]     wide_t;
   typedef logic signed [2*WIDTH-1:0] prod_t;

   word_t sample_q [N];
   word_t yr_q     [N];
   word_t yi_q     [N];

   word_t net_re [STAGES+1][N];
   word_t net_im [STAGES+1][N];

   // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.15
   function automatic word_t tw_cos(input int k);
      word_t c;
      case (k)
         0:       c = word_t'(32767);
         1:       c = word_t'(30274);
         2:       c = word_t'(23170);
         3:       c = word_t'(12540);
         4:       c = word_t'(0);
         5:       c = word_t'(-12540);
         6:       c = word_t'(-23170);
         7:       c = word_t'(-30274);
         default: c = word_t'(0);
      endcase
      return c;
   endfunction

   function automatic word_t tw_sin(input int k);
      word_t s;
      case (k)
         1:       s = word_t'(12540);
         2:       s = word_t'(23170);
         3:       s = word_t'(30274);
         4:       s = word_t'(32767);
         5:       s = word_t'(30274);
         6:       s = word_t'(23170);
         7:       s = word_t'(12540);
         default: s = word_t'(0);
      endcase
      return s;
   endfunction

   function automatic prod_t mul_full(input word_t a, input word_t b);
      prod_t ae;
      prod_t be;
      ae = {{WIDTH{a[WIDTH-1]}}, a};
      be = {{WIDTH{b[WIDTH-1]}}, b};
      return ae * be;
   endfunction

   // Product-sum back to Q1.15 by truncation (floor)
   function automatic word_t q15_trunc(input prod_t acc);
      return word_t'(acc >>> FRAC);
   endfunction

   function automatic wide_t ext(input word_t a);
      return {a[WIDTH-1], a};
   endfunction

   // Halving after the WIDTH+1 add keeps every stage inside WIDTH bits
   function automatic word_t half_floor(input wide_t s);
      return word_t'(s >>> 1);
   endfunction

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   always_comb begin
      int    j;
      int    k;
      word_t c;
      word_t sn;
      word_t ar;
      word_t ai;
      word_t br;
      word_t bi;
      word_t tr;
      word_t ti;
      j  = 0;
      k  = 0;
      c  = '0;
      sn = '0;
      ar = '0;
      ai = '0;
      br = '0;
      bi = '0;
      tr = '0;
      ti = '0;
      for (int s = 0; s <= STAGES; s++) begin
         for (int i = 0; i < N; i++) begin
            net_re[s][i] = '0;
            net_im[s][i] = '0;
         end
      end
      for (int i = 0; i < N; i++) begin
         net_re[0][i] = sample_q[bitrev4(4'(i))];
      end
      // Stage s pairs i with i+2^s; twiddle index steps by 8>>s within each group
      for (int s = 0; s < STAGES; s++) begin
         for (int i = 0; i < N; i++) begin
            if ((i & (1 << s)) == 0) begin
               j  = i + (1 << s);
               k  = (i & ((1 << s) - 1)) * ((N / 2) >> s);
               ar = net_re[s][i];
               ai = net_im[s][i];
               br = net_re[s][j];
               bi = net_im[s][j];
               if (k == 0) begin
                  tr = br;
                  ti = bi;
               end else begin
                  c  = tw_cos(k);
                  sn = tw_sin(k);
                  tr = q15_trunc(mul_full(c, br) + mul_full(sn, bi));
                  ti = q15_trunc(mul_full(c, bi) - mul_full(sn, br));
               end
               net_re[s+1][i] = half_floor(ext(ar) + ext(tr));
               net_im[s+1][i] = half_floor(ext(ai) + ext(ti));
               net_re[s+1][j] = half_floor(ext(ar) - ext(tr));
               net_im[s+1][j] = half_floor(ext(ai) - ext(ti));
            end
         end
      end
   end

   // Sample file write and output capture share the edge; outputs see the pre-write file
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            sample_q[i] <= '0;
            yr_q[i]     <= '0;
            yi_q[i]     <= '0;
         end
      end else begin
         if (load) begin
            sample_q[addr_in] <= xr_in;
         end
         for (int i = 0; i < N; i++) begin
            yr_q[i] <= net_re[STAGES][i];
            yi_q[i] <= net_im[STAGES][i];
         end
      end
   end

   assign yr_out0  = yr_q[0];
   assign yr_out1  = yr_q[1];
   assign yr_out2  = yr_q[2];
   assign yr_out3  = yr_q[3];
   assign yr_out4  = yr_q[4];
   assign yr_out5  = yr_q[5];
   assign yr_out6  = yr_q[6];
   assign yr_out7  = yr_q[7];
   assign yr_out8  = yr_q[8];
   assign yr_out9  = yr_q[9];
   assign yr_out10 = yr_q[10];
   assign yr_out11 = yr_q[11];
   assign yr_out12 = yr_q[12];
   assign yr_out13 = yr_q[13];
   assign yr_out14 = yr_q[14];
   assign yr_out15 = yr_q[15];
   assign yi_out0  = yi_q[0];
   assign yi_out1  = yi_q[1];
   assign yi_out2  = yi_q[2];
   assign yi_out3  = yi_q[3];
   assign yi_out4  = yi_q[4];
   assign yi_out5  = yi_q[5];
   assign yi_out6  = yi_q[6];
   assign yi_out7  = yi_q[7];
   assign yi_out8  = yi_q[8];
   assign yi_out9  = yi_q[9];
   assign yi_out10 = yi_q[10];
   assign yi_out11 = yi_q[11];
   assign yi_out12 = yi_q[12];
   assign yi_out13 = yi_q[13];
   assign yi_out14 = yi_q[14];
   assign yi_out15 = yi_q[15];

endmodule

// File: tb/tb_fft16_top.sv
// Self-checking bench for fft16_top: directed spectra from known frames plus randomized
// frames and write streams checked against an integer FFT reference model.
module tb_fft16_top;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                load;
   logic [3:0]          addr_in;
   logic signed [W-1:0] xr_in;
   logic signed [W-1:0] yr [16];
   logic signed [W-1:0] yi [16];

   int tests = 0;
   int fails = 0;
   int smem   [16];
   int exp_re [16];
   int exp_im [16];

   int cos_t [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
   int sin_t [8] = '{0, 12540, 23170, 30274, 32767, 30274, 23170, 12540};
   // 1024*W^k rounded, for the shifted-impulse spectrum
   int id_re [16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                      -1024, -946, -724, -392, 0, 392, 724, 946};
   int id_im [16] = '{0, -392, -724, -946, -1024, -946, -724, -392,
                      0, 392, 724, 946, 1024, 946, 724, 392};

   always #5 clk = ~clk;

   fft16_top #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load(load), .addr_in(addr_in), .xr_in(xr_in),
      .yr_out0(yr[0]),   .yr_out1(yr[1]),   .yr_out2(yr[2]),   .yr_out3(yr[3]),
      .yr_out4(yr[4]),   .yr_out5(yr[5]),   .yr_out6(yr[6]),   .yr_out7(yr[7]),
      .yr_out8(yr[8]),   .yr_out9(yr[9]),   .yr_out10(yr[10]), .yr_out11(yr[11]),
      .yr_out12(yr[12]), .yr_out13(yr[13]), .yr_out14(yr[14]), .yr_out15(yr[15]),
      .yi_out0(yi[0]),   .yi_out1(yi[1]),   .yi_out2(yi[2]),   .yi_out3(yi[3]),
      .yi_out4(yi[4]),   .yi_out5(yi[5]),   .yi_out6(yi[6]),   .yi_out7(yi[7]),
      .yi_out8(yi[8]),   .yi_out9(yi[9]),   .yi_out10(yi[10]), .yi_out11(yi[11]),
      .yi_out12(yi[12]), .yi_out13(yi[13]), .yi_out14(yi[14]), .yi_out15(yi[15])
   );

   function automatic int wrap16(input int v);
      return int'(shortint'(v));
   endfunction

   // Textbook in-place radix-2 DIT over plain ints, with the fixed-point rounding rules
   function automatic void model_fft();
      int re [16];
      int im [16];
      int r, v, half, j, k, ar, ai, br, bi, tr, ti;
      for (int n = 0; n < 16; n++) begin
         r = 0;
         v = n;
         for (int b = 0; b < 4; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
         end
         re[n] = smem[r];
         im[n] = 0;
      end
      for (int span = 2; span <= 16; span = span * 2) begin
         half = span / 2;
         for (int i = 0; i < 16; i++) begin
            if ((i % span) < half) begin
               j  = i + half;
               k  = (i % span) * (16 / span);
               ar = re[i];
               ai = im[i];
               br = re[j];
               bi = im[j];
               if (k == 0) begin
                  tr = br;
                  ti = bi;
               end else begin
                  tr = wrap16((cos_t[k] * br + sin_t[k] * bi) >>> 15);
                  ti = wrap16((cos_t[k] * bi - sin_t[k] * br) >>> 15);
               end
               re[i] = (ar + tr) >>> 1;
               im[i] = (ai + ti) >>> 1;
               re[j] = (ar - tr) >>> 1;
               im[j] = (ai - ti) >>> 1;
            end
         end
      end
      for (int n = 0; n < 16; n++) begin
         exp_re[n] = re[n];
         exp_im[n] = im[n];
      end
   endfunction

   function automatic int rnd_sample();
      case ($urandom_range(0, 5))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int val);
      load    = 1'b1;
      addr_in = 4'(a);
      xr_in   = 16'(val);
      tick();
      load    = 1'b0;
      smem[a] = val;
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      load = 1'b0;
      tick();
      rst = 1'b1;
      for (int n = 0; n < 16; n++) smem[n] = 0;
   endtask

   task automatic test_reset();
      for (int n = 0; n < 16; n++) wr(n, rnd_sample());
      tick();
      tick();
      rst     = 1'b0;
      load    = 1'b1;
      addr_in = 4'd7;
      xr_in   = 16'sd9999;
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
            fails++;
            $display("FAIL reset bin %0d: got re=%0d im=%0d, want 0 0", k, yr[k], yi[k]);
         end
      end
      rst  = 1'b1;
      load = 1'b0;
      for (int n = 0; n < 16; n++) smem[n] = 0;
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
            fails++;
            $display("FAIL reset_hold bin %0d: got re=%0d im=%0d, want 0 0", k, yr[k], yi[k]);
         end
      end
   endtask

   task automatic test_impulse();
      do_reset();
      wr(0, 32767);
      for (int n = 1; n < 16; n++) wr(n, 0);
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (int'(yr[k]) !== 2047 || int'(yi[k]) !== 0) begin
            fails++;
            $display("FAIL impulse bin %0d: got re=%0d im=%0d, want 2047 0", k, yr[k], yi[k]);
         end
      end
   endtask

   task automatic test_dc();
      do_reset();
      for (int n = 0; n < 16; n++) wr(n, 4096);
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (int'(yr[k]) !== ((k == 0) ? 4096 : 0) || int'(yi[k]) !== 0) begin
            fails++;
            $display("FAIL dc bin %0d: got re=%0d im=%0d, want %0d 0", k, yr[k], yi[k],
                     (k == 0) ? 4096 : 0);
         end
      end
   endtask

   task automatic test_nyquist();
      do_reset();
      for (int n = 0; n < 16; n++) wr(n, (n % 2 == 0) ? 4096 : -4096);
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (int'(yr[k]) !== ((k == 8) ? 4096 : 0) || int'(yi[k]) !== 0) begin
            fails++;
            $display("FAIL nyquist bin %0d: got re=%0d im=%0d, want %0d 0", k, yr[k], yi[k],
                     (k == 8) ? 4096 : 0);
         end
      end
   endtask

   task automatic test_full_scale();
      do_reset();
      for (int n = 0; n < 16; n++) wr(n, 32767);
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tests++;
         if (int'(yr[k]) !== ((k == 0) ? 32767 : 0) || int'(yi[k]) !== 0) begin
            fails++;
            $display("FAIL full_scale bin %0d: got re=%0d im=%0d, want %0d 0", k, yr[k], yi[k],
                     (k == 0) ? 32767 : 0);
         end
      end
   endtask

   task automatic test_shifted_impulse();
      int dr, di;
      do_reset();
      for (int n = 0; n < 16; n++) wr(n, (n == 1) ? 16384 : 0);
      tick();
      tick();
      model_fft();
      for (int k = 0; k < 16; k++) begin
         dr = int'(yr[k]) - id_re[k];
         di = int'(yi[k]) - id_im[k];
         tests++;
         if (dr > 1 || dr < -1 || di > 1 || di < -1) begin
            fails++;
            $display("FAIL shifted_ideal bin %0d: got re=%0d im=%0d, want %0d %0d (+-1)",
                     k, yr[k], yi[k], id_re[k], id_im[k]);
         end
         tests++;
         if (int'(yr[k]) !== exp_re[k] || int'(yi[k]) !== exp_im[k]) begin
            fails++;
            $display("FAIL shifted_exact bin %0d: got re=%0d im=%0d, want %0d %0d",
                     k, yr[k], yi[k], exp_re[k], exp_im[k]);
         end
      end
   endtask

   task automatic test_random_frames();
      do_reset();
      for (int n = 0; n < 16; n++) wr(n, rnd_sample());
      for (int f = 0; f < 8; f++) begin
         if (f > 0) begin
            for (int w = 0; w < int'($urandom_range(1, 10)); w++) begin
               wr(int'($urandom_range(0, 15)), rnd_sample());
            end
         end
         tick();
         tick();
         model_fft();
         for (int k = 0; k < 16; k++) begin
            tests++;
            if (int'(yr[k]) !== exp_re[k] || int'(yi[k]) !== exp_im[k]) begin
               fails++;
               $display("FAIL random_frame %0d bin %0d: got re=%0d im=%0d, want %0d %0d",
                        f, k, yr[k], yi[k], exp_re[k], exp_im[k]);
            end
         end
      end
   endtask

   // Each edge must expose the spectrum of the sample file as it was before that edge's write
   task automatic test_back_to_back();
      int a, v, bad;
      logic ld;
      for (int c = 0; c < 48; c++) begin
         model_fft();
         ld      = ($urandom_range(0, 3) != 0);
         a       = int'($urandom_range(0, 15));
         v       = rnd_sample();
         load    = ld;
         addr_in = 4'(a);
         xr_in   = 16'(v);
         tick();
         load = 1'b0;
         if (ld) smem[a] = v;
         bad = -1;
         for (int k = 0; k < 16; k++) begin
            if (bad < 0 && (int'(yr[k]) !== exp_re[k] || int'(yi[k]) !== exp_im[k])) bad = k;
         end
         tests++;
         if (bad >= 0) begin
            fails++;
            $display("FAIL back_to_back cycle %0d bin %0d: got re=%0d im=%0d, want %0d %0d",
                     c, bad, yr[bad], yi[bad], exp_re[bad], exp_im[bad]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wr(0, 32767);
      for (int n = 1; n < 16; n++) wr(n, 0);
      tick();
      tests++;
      if (int'(yr[0]) !== 2047) begin
         fails++;
         $display("FAIL reset_mid_pre: got yr0=%0d, want 2047", yr[0]);
      end
      rst     = 1'b0;
      load    = 1'b1;
      addr_in = 4'd5;
      xr_in   = 16'sd12345;
      tick();
      rst  = 1'b1;
      load = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 16; k++) begin
            tests++;
            if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
               fails++;
               $display("FAIL reset_mid cycle %0d bin %0d: got re=%0d im=%0d, want 0 0",
                        c, k, yr[k], yi[k]);
            end
         end
         tick();
      end
      for (int n = 0; n < 16; n++) smem[n] = 0;
   endtask

   initial begin
      rst     = 1'b0;
      load    = 1'b0;
      addr_in = 4'd0;
      xr_in   = '0;
      for (int n = 0; n < 16; n++) smem[n] = 0;
      tick();
      tick();
      rst = 1'b1;
      test_reset();
      test_impulse();
      test_dc();
      test_nyquist();
      test_full_scale();
      test_shifted_impulse();
      test_random_frames();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
